me_frame_sched: RTL and testbench
=================================

// Module: me_frame_sched
// PURPOSE
//  Frame-level scheduler for the motion-estimation engine (me). Walks the frame's macroblocks in raster order.
//  Per MB: issues one start to the engine and exports the MB coordinates to the search/current RAM address logic.
//  Accepts each result over the engine's valido/readyo handshake, tags it with its coordinates.
//  Tagged results are buffered in a small FIFO feeding the downstream mode-decision/entropy stage.
// PARAMETERS
//  MACRO_DIM   4   macroblock edge in pixels; passed through to me_pkg constants
//  SEARCH_DIM  16  search-window edge in pixels; informational, matches the engine
//  FRAME_W_MB  8   frame width in macroblocks (>=1)
//  FRAME_H_MB  6   frame height in macroblocks (>=1)
//  FIFO_DEPTH  4   result FIFO entries; power of two, >=2
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  rst          in   1   asynchronous, active-high reset
//  frame_start  in   1   1-cycle pulse: begin a frame; ignored unless IDLE
//  frame_busy   out  1   high from the cycle after an accepted frame_start until frame_done
//  frame_done   out  1   1-cycle pulse: all results of the frame popped from the FIFO
//  mb_x         out  CW  current MB column, CW=$clog2(FRAME_W_MB) (min 1)
//  mb_y         out  RW  current MB row, RW=$clog2(FRAME_H_MB) (min 1)
//  me_start     out  1   1-cycle start pulse to the engine
//  me_readyi    in   1   engine idle and able to accept start
//  me_valido    in   1   engine result valid
//  me_readyo    out  1   scheduler accepts result
//  me_mv_x      in   6   engine motion vector x
//  me_mv_y      in   6   engine motion vector y
//  me_min_sad   in   16  engine minimum SAD
//  res_valid    out  1   FIFO head valid
//  res_ready    in   1   downstream accepts head
//  res_mb_x     out  CW  head MB column
//  res_mb_y     out  RW  head MB row
//  res_mv_x     out  6   head MV x
//  res_mv_y     out  6   head MV y
//  res_sad      out  16  head SAD
//  res_last     out  1   head is the frame's final MB
// BEHAVIOUR
//  Reset: state=IDLE, mb_x=mb_y=0, FIFO empty.
//  Reset: all outputs 0, including frame_busy, frame_done, me_start, me_readyo, res_valid and all res_* fields.
//  FSM:
//   IDLE   -> LAUNCH on frame_start. Counters cleared to 0 in the same edge.
//   LAUNCH -> when me_readyi=1 and FIFO count<FIFO_DEPTH: assert me_start for exactly one cycle, then go to WAIT.
//   LAUNCH stalls indefinitely otherwise; me_start stays 0 while stalled.
//   WAIT   me_readyo=1 (the LAUNCH check guarantees a free slot).
//   WAIT   on me_valido&&me_readyo: push {mb_x,mb_y,mv,sad,last}; last=(mb_x==W-1 && mb_y==H-1).
//   WAIT   after the push: last -> DRAIN; else advance raster (mb_x wraps to 0 and mb_y++) -> LAUNCH.
//   DRAIN  -> when FIFO empty: pulse frame_done, go to IDLE in the same edge.
//  mb_x/mb_y hold stable from LAUNCH through the accepting WAIT edge; the address generator may use them directly.
//  FIFO: first-word-fall-through. A pop happens on res_valid&&res_ready.
//  FIFO: simultaneous push and pop is legal in any state; count is unchanged.
//  me_start is never asserted while a result is outstanding; at most one MB is in flight.
//  frame_start while not IDLE is ignored; no queuing.
//  1x1 frame: the first result has last=1 and goes straight to DRAIN.
//  Reset mid-frame: FSM, counters and FIFO are cleared immediately. Results already buffered are discarded.
//  Reset mid-frame: the engine is reset by the same rst (inverted at the me instance).
// CONFIGURATION
//  `ME_SAD_ACCUM_EN defined: adds output frame_sad[23:0].
//   frame_sad clears on an accepted frame_start and adds me_min_sad on every push.
//   frame_sad saturates at 24'hFFFFFF, holds after frame_done, and resets to 0.
//  Undefined: no frame_sad port and no accumulator logic.
// STRUCTURE
//  me_pkg: sched_state_t enum {IDLE,LAUNCH,WAIT,DRAIN}; me_result_t struct {mb_x,mb_y,mv_x,mv_y,sad,last}.
//  me_pkg: MV_W=6, SAD_W=16, FSAD_W=24.
//  Sub-module me_result_fifo: parameterised on FIFO_DEPTH, stores me_result_t.
//  me_result_fifo: exposes push/pop/full/empty/count.
// TESTING
//  1. Reset, then 2x2 frame; engine returns sad=10,20,30,40 one cycle after each start; res_ready=1.
//     -> 4 results (0,0),(1,0),(0,1),(1,1); last only on (1,1); frame_done 1 cycle after the last pop.
//  2. res_ready=0 with FIFO_DEPTH=4 on an 8x6 frame -> exactly 4 me_start pulses, then me_start held 0.
//     Raise res_ready -> scheduling resumes in order.
//  3. Engine holds me_readyi=0 for 20 cycles in LAUNCH -> me_start stays 0 and mb_x/mb_y stay stable.
//     Start is issued on the first cycle readyi=1.
//  4. frame_start pulsed again mid-frame -> ignored; frame_done appears once only.
//     Result count equals FRAME_W_MB*FRAME_H_MB=48.
//  5. rst asserted in WAIT with 2 entries buffered -> next cycle res_valid=0, frame_busy=0, mb_x=mb_y=0.
//     A new frame then runs cleanly.
//  6. `ME_SAD_ACCUM_EN with every sad=16'hFFFF on an 8x6 frame -> frame_sad=48*65535=3145680.
//     Forcing 300 pushes -> frame_sad saturates at 24'hFFFFFF.

Source files
------------

// File: rtl/me_pkg.sv
// me_pkg: shared types and widths for the motion-estimation frame scheduler.
// Result records carry 8-bit MB coordinates; frames up to 256x256 MBs.
package me_pkg;

    localparam int MV_W    = 6;
    localparam int SAD_W   = 16;
    localparam int FSAD_W  = 24;
    localparam int COORD_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DRAIN
    } sched_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] mb_x;
        logic [COORD_W-1:0] mb_y;
        logic [MV_W-1:0]    mv_x;
        logic [MV_W-1:0]    mv_y;
        logic [SAD_W-1:0]   sad;
        logic               last;
    } me_result_t;

    // Index width for a counter over n items, never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/me_frame_sched_if.sv
// me_frame_sched_if: frame control, engine handshake and result stream.
// frame_sad exists only when ME_SAD_ACCUM_EN is defined.
interface me_frame_sched_if #(
    parameter int CW = 3,
    parameter int RW = 3
);
    import me_pkg::*;

    logic               frame_start;
    logic               frame_busy;
    logic               frame_done;
    logic [CW-1:0]      mb_x;
    logic [RW-1:0]      mb_y;
    logic               me_start;
    logic               me_readyi;
    logic               me_valido;
    logic               me_readyo;
    logic [MV_W-1:0]    me_mv_x;
    logic [MV_W-1:0]    me_mv_y;
    logic [SAD_W-1:0]   me_min_sad;
    logic               res_valid;
    logic               res_ready;
    logic [CW-1:0]      res_mb_x;
    logic [RW-1:0]      res_mb_y;
    logic [MV_W-1:0]    res_mv_x;
    logic [MV_W-1:0]    res_mv_y;
    logic [SAD_W-1:0]   res_sad;
    logic               res_last;
`ifdef ME_SAD_ACCUM_EN
    logic [FSAD_W-1:0]  frame_sad;
`endif

    modport master (
        input  frame_start, me_readyi, me_valido,
        input  me_mv_x, me_mv_y, me_min_sad, res_ready,
        output frame_busy, frame_done, mb_x, mb_y,
        output me_start, me_readyo, res_valid,
        output res_mb_x, res_mb_y, res_mv_x, res_mv_y,
        output res_sad, res_last
`ifdef ME_SAD_ACCUM_EN
        , output frame_sad
`endif
    );

    modport slave (
        output frame_start, me_readyi, me_valido,
        output me_mv_x, me_mv_y, me_min_sad, res_ready,
        input  frame_busy, frame_done, mb_x, mb_y,
        input  me_start, me_readyo, res_valid,
        input  res_mb_x, res_mb_y, res_mv_x, res_mv_y,
        input  res_sad, res_last
`ifdef ME_SAD_ACCUM_EN
        , input frame_sad
`endif
    );

endinterface

// File: rtl/me_result_fifo.sv
// me_result_fifo: first-word-fall-through FIFO of tagged ME results.
// Head reads as zero while empty so downstream fields idle at 0.
module me_result_fifo
    import me_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  me_result_t       data_i,
    input  logic             pop_i,
    output me_result_t       data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    me_result_t       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // Storage write; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/me_frame_sched.sv
// me_frame_sched: walks a frame's MBs in raster order, one in flight.
// Define ME_SAD_ACCUM_EN to add the saturating frame_sad accumulator.
module me_frame_sched
    import me_pkg::*;
#(
    parameter int MACRO_DIM  = 4,
    parameter int SEARCH_DIM = 16,
    parameter int FRAME_W_MB = 8,
    parameter int FRAME_H_MB = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    me_frame_sched_if.master bus
);

    localparam int CW    = idx_w(FRAME_W_MB);
    localparam int RW    = idx_w(FRAME_H_MB);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    generate
        if (FRAME_W_MB < 1 || FRAME_H_MB < 1 ||
            FRAME_W_MB > 256 || FRAME_H_MB > 256 ||
            FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            SEARCH_DIM < MACRO_DIM) begin : g_bad_cfg
            $error("me_frame_sched: illegal parameters");
        end
    endgenerate

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic [CW-1:0]    mb_x_q;
    logic [CW-1:0]    mb_x_d;
    logic [RW-1:0]    mb_y_q;
    logic [RW-1:0]    mb_y_d;
    logic             is_last;
    logic             accept;
    logic             push;
    logic             pop;
    logic             me_start;
    logic             me_readyo;
    logic             frame_done;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    me_result_t       push_data;
    me_result_t       head;
    logic             unused_bits;

    assign is_last = (mb_x_q == CW'(FRAME_W_MB - 1)) &&
                     (mb_y_q == RW'(FRAME_H_MB - 1));
    assign accept  = (state_q == WAIT) && bus.me_valido;
    assign pop     = bus.res_ready && !fifo_empty;

    // State register and MB raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mb_x_q  <= '0;
            mb_y_q  <= '0;
        end else begin
            state_q <= state_d;
            mb_x_q  <= mb_x_d;
            mb_y_q  <= mb_y_d;
        end
    end

    // Next state and raster advance after each accepted result
    always_comb begin
        state_d = state_q;
        mb_x_d  = mb_x_q;
        mb_y_d  = mb_y_q;
        unique case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    state_d = LAUNCH;
                    mb_x_d  = '0;
                    mb_y_d  = '0;
                end
            end
            LAUNCH: begin
                if (bus.me_readyi && !fifo_full) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (accept) begin
                    if (is_last) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = LAUNCH;
                        if (mb_x_q == CW'(FRAME_W_MB - 1)) begin
                            mb_x_d = '0;
                            mb_y_d = mb_y_q + 1'b1;
                        end else begin
                            mb_x_d = mb_x_q + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Engine handshake, result push and frame completion strobe
    always_comb begin
        me_start   = 1'b0;
        me_readyo  = 1'b0;
        push       = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            LAUNCH: me_start = bus.me_readyi && !fifo_full;
            WAIT: begin
                me_readyo = 1'b1;
                push      = bus.me_valido;
            end
            DRAIN:   frame_done = fifo_empty;
            default: ;
        endcase
    end

    // Tag the engine result with the MB it belongs to
    always_comb begin
        push_data      = '0;
        push_data.mb_x = COORD_W'(mb_x_q);
        push_data.mb_y = COORD_W'(mb_y_q);
        push_data.mv_x = bus.me_mv_x;
        push_data.mv_y = bus.me_mv_y;
        push_data.sad  = bus.me_min_sad;
        push_data.last = is_last;
    end

    me_result_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .data_i (push_data),
        .pop_i  (pop),
        .data_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt)
    );

    assign unused_bits    = ^{head.mb_x, head.mb_y, fifo_cnt};

    assign bus.frame_busy = (state_q != IDLE);
    assign bus.frame_done = frame_done;
    assign bus.mb_x       = mb_x_q;
    assign bus.mb_y       = mb_y_q;
    assign bus.me_start   = me_start;
    assign bus.me_readyo  = me_readyo;
    assign bus.res_valid  = !fifo_empty;
    assign bus.res_mb_x   = head.mb_x[CW-1:0];
    assign bus.res_mb_y   = head.mb_y[RW-1:0];
    assign bus.res_mv_x   = head.mv_x;
    assign bus.res_mv_y   = head.mv_y;
    assign bus.res_sad    = head.sad;
    assign bus.res_last   = head.last;

`ifdef ME_SAD_ACCUM_EN
    logic [FSAD_W-1:0] fsad_q;
    logic [FSAD_W:0]   fsad_sum;

    assign fsad_sum = {1'b0, fsad_q} + (FSAD_W + 1)'(bus.me_min_sad);

    // Frame SAD: cleared on frame accept, saturating add per push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsad_q <= '0;
        end else if (state_q == IDLE && bus.frame_start) begin
            fsad_q <= '0;
        end else if (push) begin
            fsad_q <= fsad_sum[FSAD_W] ? '1 : fsad_sum[FSAD_W-1:0];
        end
    end

    assign bus.frame_sad = fsad_q;
`endif

endmodule

// File: tb/tb_me_frame_sched.sv
// tb_me_frame_sched: directed checks of me_frame_sched on 2x2 and 8x6 frames.
// With ME_SAD_ACCUM_EN a 20x15 instance exercises frame_sad saturation.
module tb_me_frame_sched;
    import me_pkg::*;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [5:0]  mvx;
        logic [5:0]  mvy;
        logic [15:0] sad;
        logic        last;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    me_frame_sched_if #(.CW(1), .RW(1)) ba();
    me_frame_sched_if #(.CW(3), .RW(3)) bb();

    me_frame_sched #(
        .FRAME_W_MB(2), .FRAME_H_MB(2), .FIFO_DEPTH(4)
    ) u_a (.clk(clk), .rst(rst), .bus(ba));

    me_frame_sched #(
        .FRAME_W_MB(8), .FRAME_H_MB(6), .FIFO_DEPTH(4)
    ) u_b (.clk(clk), .rst(rst), .bus(bb));

`ifdef ME_SAD_ACCUM_EN
    me_frame_sched_if #(.CW(5), .RW(4)) bc();
    me_frame_sched #(
        .FRAME_W_MB(20), .FRAME_H_MB(15), .FIFO_DEPTH(4)
    ) u_c (.clk(clk), .rst(rst), .bus(bc));
    int c_done = 0;
    int c_pops = 0;
`endif

    logic a_hold   = 1'b0;
    logic b_sadmax = 1'b0;
    rec_t a_pops[$];
    rec_t b_pops[$];
    int   a_done = 0;
    int   b_done = 0;
    int   b_starts = 0;
    int   a_pop_cyc = 0;
    int   a_done_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int get_done(input int sel);
        if (sel == 0) return a_done;
        if (sel == 1) return b_done;
`ifdef ME_SAD_ACCUM_EN
        return c_done;
`else
        return 0;
`endif
    endfunction

    task automatic wait_done(input int sel, input int target,
                             input int budget, input string nm);
        int n = 0;
        while (get_done(sel) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(get_done(sel) >= target), 64'd1);
    endtask

    // Engine model for the 2x2 instance: result one cycle after start
    initial begin : eng_a
        logic st;
        logic acc;
        int   idx;
        ba.me_valido  = 1'b0;
        ba.me_mv_x    = '0;
        ba.me_mv_y    = '0;
        ba.me_min_sad = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                ba.me_valido = 1'b0;
            end else begin
                st  = ba.me_start;
                acc = ba.me_valido && ba.me_readyo;
                idx = int'(ba.mb_y) * 2 + int'(ba.mb_x);
                #1;
                if (acc) ba.me_valido = 1'b0;
                if (st && !(a_hold && idx >= 2)) begin
                    ba.me_valido  = 1'b1;
                    ba.me_mv_x    = 6'(idx);
                    ba.me_mv_y    = 6'(idx + 32);
                    ba.me_min_sad = 16'(10 * (idx + 1));
                end
            end
        end
    end

    // Engine model for the 8x6 instance
    initial begin : eng_b
        logic st;
        logic acc;
        int   idx;
        bb.me_valido  = 1'b0;
        bb.me_mv_x    = '0;
        bb.me_mv_y    = '0;
        bb.me_min_sad = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                bb.me_valido = 1'b0;
            end else begin
                st  = bb.me_start;
                acc = bb.me_valido && bb.me_readyo;
                idx = int'(bb.mb_y) * 8 + int'(bb.mb_x);
                #1;
                if (acc) bb.me_valido = 1'b0;
                if (st) begin
                    bb.me_valido  = 1'b1;
                    bb.me_mv_x    = 6'(idx);
                    bb.me_mv_y    = 6'(idx + 32);
                    bb.me_min_sad = b_sadmax ? 16'hFFFF : 16'(idx);
                end
            end
        end
    end

`ifdef ME_SAD_ACCUM_EN
    initial begin : eng_c
        logic st;
        logic acc;
        bc.me_valido  = 1'b0;
        bc.me_mv_x    = '0;
        bc.me_mv_y    = '0;
        bc.me_min_sad = 16'hFFFF;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                bc.me_valido = 1'b0;
            end else begin
                st  = bc.me_start;
                acc = bc.me_valido && bc.me_readyo;
                #1;
                if (acc) bc.me_valido = 1'b0;
                if (st) bc.me_valido = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (bc.res_valid && bc.res_ready) c_pops++;
        if (bc.frame_done) c_done++;
    end
`endif

    // Result and strobe monitors
    always @(negedge clk) begin
        rec_t r;
        if (ba.res_valid && ba.res_ready) begin
            r = '{x: 8'(ba.res_mb_x), y: 8'(ba.res_mb_y),
                  mvx: ba.res_mv_x, mvy: ba.res_mv_y,
                  sad: ba.res_sad, last: ba.res_last};
            a_pops.push_back(r);
            a_pop_cyc = cyc;
        end
        if (ba.frame_done) begin
            a_done++;
            a_done_cyc = cyc;
        end
        if (bb.res_valid && bb.res_ready) begin
            r = '{x: 8'(bb.res_mb_x), y: 8'(bb.res_mb_y),
                  mvx: bb.res_mv_x, mvy: bb.res_mv_y,
                  sad: bb.res_sad, last: bb.res_last};
            b_pops.push_back(r);
        end
        if (bb.frame_done) b_done++;
        if (bb.me_start) b_starts++;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    rec_t t1[4];

    task automatic check_table_a(input int base, input string tag);
        chk({tag, "_count"}, 64'(a_pops.size() - base), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < a_pops.size())
                chk($sformatf("%s_res%0d", tag, i), 64'(a_pops[base + i]),
                    64'(t1[i]));
        end
    endtask

    task automatic run_frame_a(input string tag);
        int base;
        int d0;
        base = a_pops.size();
        d0   = a_done;
        tick();
        ba.frame_start = 1'b1;
        @(negedge clk);
        chk({tag, "_busy_pre"}, 64'(ba.frame_busy), 64'd0);
        tick();
        ba.frame_start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, 64'(ba.frame_busy), 64'd1);
        chk({tag, "_start"}, 64'(ba.me_start), 64'd1);
        wait_done(0, d0 + 1, 60, {tag, "_done_seen"});
        chk({tag, "_done_lat"}, 64'(a_done_cyc - a_pop_cyc), 64'd1);
        repeat (5) @(negedge clk);
        chk({tag, "_done_once"}, 64'(a_done - d0), 64'd1);
        chk({tag, "_idle"}, 64'(ba.frame_busy), 64'd0);
        check_table_a(base, tag);
    endtask

    initial begin : main
        int   base;
        int   sb;
        int   d0;
        int   viol;
        rec_t e;

        t1[0] = '{x: 8'd0, y: 8'd0, mvx: 6'd0, mvy: 6'd32, sad: 16'd10, last: 1'b0};
        t1[1] = '{x: 8'd1, y: 8'd0, mvx: 6'd1, mvy: 6'd33, sad: 16'd20, last: 1'b0};
        t1[2] = '{x: 8'd0, y: 8'd1, mvx: 6'd2, mvy: 6'd34, sad: 16'd30, last: 1'b0};
        t1[3] = '{x: 8'd1, y: 8'd1, mvx: 6'd3, mvy: 6'd35, sad: 16'd40, last: 1'b1};

        rst            = 1'b1;
        ba.frame_start = 1'b0;
        ba.me_readyi   = 1'b1;
        ba.res_ready   = 1'b0;
        bb.frame_start = 1'b0;
        bb.me_readyi   = 1'b1;
        bb.res_ready   = 1'b0;
`ifdef ME_SAD_ACCUM_EN
        bc.frame_start = 1'b0;
        bc.me_readyi   = 1'b1;
        bc.res_ready   = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk("reset_ctl", 64'({ba.frame_busy, ba.frame_done, ba.me_start,
                              ba.me_readyo, ba.res_valid, ba.res_last}), 64'd0);
        chk("reset_mb", 64'({ba.mb_x, ba.mb_y}), 64'd0);
        chk("reset_res", 64'({ba.res_mb_x, ba.res_mb_y, ba.res_mv_x,
                              ba.res_mv_y, ba.res_sad}), 64'd0);
        tick();
        rst = 1'b0;

        // 2x2 frame, downstream always ready
        ba.res_ready = 1'b1;
        run_frame_a("t1");

        // Reset while waiting on the engine with two results buffered
        ba.res_ready = 1'b0;
        a_hold       = 1'b1;
        tick();
        ba.frame_start = 1'b1;
        tick();
        ba.frame_start = 1'b0;
        repeat (12) @(negedge clk);
        chk("t5_pre", 64'({ba.res_valid, ba.me_readyo, ba.mb_x, ba.mb_y}),
            64'({1'b1, 1'b1, 1'b0, 1'b1}));
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst", 64'({ba.res_valid, ba.frame_busy, ba.mb_x, ba.mb_y,
                           ba.me_readyo}), 64'd0);
        tick();
        rst          = 1'b0;
        a_hold       = 1'b0;
        ba.res_ready = 1'b1;
        @(negedge clk);
        chk("t5_after", 64'({ba.res_valid, ba.frame_busy}), 64'd0);
        run_frame_a("t5");

        // 8x6 frame: FIFO back-pressure, ignored restart, engine stall
        base = b_pops.size();
        sb   = b_starts;
        d0   = b_done;
        tick();
        bb.frame_start = 1'b1;
        tick();
        bb.frame_start = 1'b0;
        repeat (30) @(negedge clk);
        chk("t2_starts", 64'(b_starts - sb), 64'd4);
        chk("t2_start_low", 64'(bb.me_start), 64'd0);
        chk("t2_mb_hold", 64'({bb.mb_x, bb.mb_y}), 64'({3'd4, 3'd0}));
        chk("t2_head", 64'({bb.res_valid, bb.res_mb_x, bb.res_mb_y}),
            64'({1'b1, 3'd0, 3'd0}));
        tick();
        bb.frame_start = 1'b1;
        tick();
        bb.frame_start = 1'b0;
        @(negedge clk);
        chk("t4_ignored", 64'({bb.frame_busy, bb.mb_x, bb.mb_y}),
            64'({1'b1, 3'd4, 3'd0}));
        chk("t4_starts", 64'(b_starts - sb), 64'd4);
        tick();
        bb.me_readyi = 1'b0;
        bb.res_ready = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (bb.me_start || bb.mb_x != 3'd4 || bb.mb_y != 3'd0) viol++;
        end
        chk("t3_stall", 64'(viol), 64'd0);
        chk("t3_drained", 64'(b_pops.size() - base), 64'd4);
        tick();
        bb.me_readyi = 1'b1;
        @(negedge clk);
        chk("t3_first_start", 64'(bb.me_start), 64'd1);
        wait_done(1, d0 + 1, 400, "t4_done_seen");
        repeat (5) @(negedge clk);
        chk("t4_done_once", 64'(b_done - d0), 64'd1);
        chk("t4_idle", 64'(bb.frame_busy), 64'd0);
        chk("t4_count", 64'(b_pops.size() - base), 64'd48);
        for (int i = 0; i < 48; i++) begin
            e = '{x: 8'(i % 8), y: 8'(i / 8), mvx: 6'(i), mvy: 6'(i + 32),
                  sad: 16'(i), last: (i == 47)};
            if (base + i < b_pops.size())
                chk($sformatf("t2_order%0d", i), 64'(b_pops[base + i]),
                    64'(e));
        end

`ifdef ME_SAD_ACCUM_EN
        // Accumulated SAD: ramp, full-scale frame, then saturation
        chk("t6_ramp_sum", 64'(bb.frame_sad), 64'd1128);
        b_sadmax = 1'b1;
        d0       = b_done;
        tick();
        bb.frame_start = 1'b1;
        tick();
        bb.frame_start = 1'b0;
        @(negedge clk);
        chk("t6_clear", 64'(bb.frame_sad), 64'd0);
        wait_done(1, d0 + 1, 400, "t6_done_seen");
        chk("t6_sum", 64'(bb.frame_sad), 64'd3145680);
        repeat (5) @(negedge clk);
        chk("t6_hold", 64'(bb.frame_sad), 64'd3145680);
        tick();
        bc.frame_start = 1'b1;
        tick();
        bc.frame_start = 1'b0;
        wait_done(2, 1, 1500, "t6_sat_done_seen");
        chk("t6_sat_pushes", 64'(c_pops), 64'd300);
        chk("t6_sat", 64'(bc.frame_sad), 64'hFFFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
